// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the scalar/vector data-memory arbiter.
package dmem_arbiter_pkg;
    localparam int MAX_VL_DEF = 8;
    localparam int LEN_W_DEF  = 4;
    localparam int ELEM_W     = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        VBURST = 1'b1
    } state_t;
endpackage

// File: rtl/dmem_arbiter_vburst_addr_gen.sv
// Strided burst address accumulator and element counter; one element per step, no multiplier.
// load latches base/stride/len, step advances; last flags the final element of the burst.
module vburst_addr_gen
    import dmem_arbiter_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      base,
    input  logic [31:0]      stride,
    input  logic [LEN_W-1:0] len,
    output logic [31:0]      addr,
    output logic [LEN_W-1:0] idx,
    output logic             last
);
    logic [31:0]      stride_q;
    logic [LEN_W-1:0] len_m1;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            stride_q <= '0;
            idx      <= '0;
            len_m1   <= '0;
        end else if (load) begin
            addr     <= base;
            stride_q <= stride;
            idx      <= '0;
            len_m1   <= len - LEN_W'(1);
        end else if (step) begin
            // two's-complement add gives the mod-2^32 wrap for negative strides
            addr <= addr + stride_q;
            idx  <= idx + LEN_W'(1);
        end
    end

    assign last = (idx == len_m1);
endmodule

// File: rtl/dmem_arbiter.sv
// Scalar/vector arbiter for one single-port data memory: scalar 1-cycle access, vector bursts 1 element/cycle.
// Grants are combinational, read data/done registered; the scalar stalls for the whole burst, ties alternate via prio_v.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_VL = MAX_VL_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     reset,
    input  logic                     s_req_i,
    input  logic                     s_we_i,
    input  logic [31:0]              s_addr_i,
    input  logic [31:0]              s_wdata_i,
    output logic                     s_gnt_o,
    output logic                     s_rvalid_o,
    output logic [31:0]              s_rdata_o,
    input  logic                     v_req_i,
    input  logic                     v_we_i,
    input  logic [31:0]              v_base_i,
    input  logic [31:0]              v_stride_i,
    input  logic [LEN_W-1:0]         v_len_i,
    input  logic [ELEM_W*MAX_VL-1:0] v_wdata_i,
    output logic                     v_gnt_o,
    output logic                     v_done_o,
    output logic [ELEM_W*MAX_VL-1:0] v_rdata_o,
    output logic [31:0]              mem_addr_o,
    output logic [31:0]              mem_wdata_o,
    output logic                     mem_write_o,
    output logic                     mem_read_o,
    input  logic [31:0]              mem_rdata_i
);
    localparam int DATA_W = ELEM_W * MAX_VL;

    state_t            state;
    logic              prio_v;
    logic              v_we_q;
    logic [DATA_W-1:0] v_wdata_q;
    logic [LEN_W-1:0]  len_c;
    logic [LEN_W-1:0]  ag_idx;
    logic [31:0]       ag_addr;
    logic              ag_last;
    logic              idle;
    logic              in_burst;
    logic              s_win;

    assign len_c = (v_len_i > LEN_W'(MAX_VL)) ? LEN_W'(MAX_VL) : v_len_i;

    // Nothing is granted or accessed while reset is held, so a reset mid-burst stops memory traffic at once.
    assign idle     = (state == IDLE) && !reset;
    assign in_burst = (state == VBURST) && !reset;
    assign s_win    = s_req_i && (!v_req_i || !prio_v);
    assign s_gnt_o  = idle && s_win;
    assign v_gnt_o  = idle && v_req_i && !s_win;

    vburst_addr_gen #(
        .LEN_W(LEN_W)
    ) u_addr_gen (
        .clk    (clk_i),
        .reset  (reset),
        .load   (v_gnt_o),
        .step   (in_burst),
        .base   (v_base_i),
        .stride (v_stride_i),
        .len    (len_c),
        .addr   (ag_addr),
        .idx    (ag_idx),
        .last   (ag_last)
    );

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        if (s_gnt_o) begin
            mem_addr_o  = s_addr_i;
            mem_wdata_o = s_wdata_i;
            mem_write_o = s_we_i;
            mem_read_o  = !s_we_i;
        end else if (in_burst) begin
            mem_addr_o  = ag_addr;
            mem_wdata_o = v_wdata_q[ag_idx*ELEM_W +: ELEM_W];
            mem_write_o = v_we_q;
            mem_read_o  = !v_we_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= IDLE;
            prio_v     <= 1'b0;
            s_rvalid_o <= 1'b0;
            s_rdata_o  <= '0;
            v_done_o   <= 1'b0;
            v_rdata_o  <= '0;
            v_we_q     <= 1'b0;
            v_wdata_q  <= '0;
        end else begin
            s_rvalid_o <= 1'b0;
            v_done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_gnt_o) begin
                        prio_v <= 1'b1;
                        if (!s_we_i) begin
                            s_rdata_o  <= mem_rdata_i;
                            s_rvalid_o <= 1'b1;
                        end
                    end else if (v_gnt_o) begin
                        prio_v    <= 1'b0;
                        v_we_q    <= v_we_i;
                        v_wdata_q <= v_wdata_i;
                        v_rdata_o <= '0;
                        // an empty burst completes without ever entering VBURST
                        if (len_c == '0) begin
                            v_done_o <= 1'b1;
                        end else begin
                            state <= VBURST;
                        end
                    end
                end
                VBURST: begin
                    if (!v_we_q) begin
                        v_rdata_o[ag_idx*ELEM_W +: ELEM_W] <= mem_rdata_i;
                    end
                    if (ag_last) begin
                        state    <= IDLE;
                        v_done_o <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of vector bursts plus hand-written scalar, contention and reset sequences.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int MAX_VL = 8;
    localparam int LEN_W  = 4;
    localparam int DW     = 32 * MAX_VL;

    logic              clk_i = 1'b0;
    logic              reset;
    logic              s_req_i, s_we_i;
    logic [31:0]       s_addr_i, s_wdata_i;
    logic              s_gnt_o, s_rvalid_o;
    logic [31:0]       s_rdata_o;
    logic              v_req_i, v_we_i;
    logic [31:0]       v_base_i, v_stride_i;
    logic [LEN_W-1:0]  v_len_i;
    logic [DW-1:0]     v_wdata_i;
    logic              v_gnt_o, v_done_o;
    logic [DW-1:0]     v_rdata_o;
    logic [31:0]       mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic              mem_write_o, mem_read_o;

    dmem_arbiter #(.MAX_VL(MAX_VL), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i), .reset(reset),
        .s_req_i(s_req_i), .s_we_i(s_we_i), .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i),
        .s_gnt_o(s_gnt_o), .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o),
        .v_req_i(v_req_i), .v_we_i(v_we_i), .v_base_i(v_base_i), .v_stride_i(v_stride_i),
        .v_len_i(v_len_i), .v_wdata_i(v_wdata_i), .v_gnt_o(v_gnt_o), .v_done_o(v_done_o),
        .v_rdata_o(v_rdata_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // 64-word memory; byte addresses alias modulo 256 so 0xFFFFFFFC lands on word 63.
    logic [31:0] mem [0:63];
    logic [31:0] exp_mem [0:63];
    logic        pl_we;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;
    assign mem_rdata_i = mem[mem_addr_o[7:2]];
    always @(posedge clk_i) begin
        if (mem_write_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
        else if (pl_we) mem[pl_idx] <= pl_dat;
    end

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic             we;
        logic [31:0]      base;
        logic [31:0]      stride;
        logic [LEN_W-1:0] len;
        logic [31:0]      dseed;
        int               exp_n;
    } vcase_t;

    acc_t   exp_q[$];
    vcase_t vt[8];
    int     checks = 0;
    int     failures = 0;
    int     acc_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        acc_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        exp_q.push_back(e);
        if (we) exp_mem[addr[7:2]] = wdata;
    endtask

    // Scoreboard: every memory access seen must be the next one the bench expects.
    always @(negedge clk_i) begin
        acc_t e;
        if (mem_read_o || mem_write_o) begin
            acc_cnt++;
            chk("rd_wr_excl", {255'd0, mem_read_o && mem_write_o}, '0);
            if (exp_q.size() == 0) begin
                chk("unexpected_access", {223'd0, mem_write_o, mem_addr_o}, '1);
            end else begin
                e = exp_q.pop_front();
                chk("mem_we", {255'd0, mem_write_o}, {255'd0, e.we});
                chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, e.addr});
                if (e.we) chk("mem_wdata", {224'd0, mem_wdata_o}, {224'd0, e.wdata});
            end
        end
    end

    task automatic s_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rd;
        int got;
        exp_rd = exp_mem[addr[7:2]];
        push(we, addr, we ? wdata : 32'd0);
        s_req_i = 1'b1; s_we_i = we; s_addr_i = addr; s_wdata_i = wdata;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk_i);
            if (s_gnt_o) got = 1;
        end
        chk("s_gnt", got, 1);
        @(posedge clk_i); #1;
        s_req_i = 1'b0;
        @(negedge clk_i);
        chk("s_rvalid", {255'd0, s_rvalid_o}, {255'd0, !we});
        if (!we) chk("s_rdata", {224'd0, s_rdata_o}, {224'd0, exp_rd});
        @(posedge clk_i); #1;
    endtask

    task automatic run_vec(input vcase_t c, input int id);
        int eff, t, got;
        logic [DW-1:0] wd, exp_rd;
        logic [31:0] a;
        eff = (int'(c.len) > MAX_VL) ? MAX_VL : int'(c.len);
        wd = '0;
        exp_rd = '0;
        for (int k = 0; k < MAX_VL; k++) wd[k*32 +: 32] = c.dseed * (k + 1);
        for (int k = 0; k < eff; k++) begin
            a = c.base + c.stride * k;
            if (c.we) push(1'b1, a, wd[k*32 +: 32]);
            else begin
                exp_rd[k*32 +: 32] = exp_mem[a[7:2]];
                push(1'b0, a, 32'd0);
            end
        end
        acc_cnt = 0;
        v_req_i = 1'b1; v_we_i = c.we; v_base_i = c.base; v_stride_i = c.stride;
        v_len_i = c.len; v_wdata_i = wd;
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk_i);
            if (v_gnt_o) got = 1;
        end
        chk($sformatf("vec%0d_gnt", id), got, 1);
        @(posedge clk_i); #1;
        v_req_i = 1'b0;
        t = 0; got = 0;
        while (got == 0 && t < 20) begin
            @(negedge clk_i);
            t++;
            if (v_done_o) got = 1;
        end
        chk($sformatf("vec%0d_done_lat", id), t, eff + 1);
        chk($sformatf("vec%0d_rdata", id), v_rdata_o, exp_rd);
        chk($sformatf("vec%0d_accesses", id), acc_cnt, c.exp_n);
        chk($sformatf("vec%0d_sb_empty", id), exp_q.size(), 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] exp_rd;
        logic [31:0]   a;
        int            ok;

        vt[0] = '{1'b1, 32'h00, 32'd4,        4'd4,  32'h11,       4};
        vt[1] = '{1'b0, 32'h00, 32'd4,        4'd4,  32'h0,        4};
        vt[2] = '{1'b1, 32'h04, 32'hFFFFFFFC, 4'd3,  32'hA0,       3};
        vt[3] = '{1'b0, 32'h04, 32'hFFFFFFFC, 4'd3,  32'h0,        3};
        vt[4] = '{1'b0, 32'h00, 32'd4,        4'd0,  32'h0,        0};
        vt[5] = '{1'b1, 32'h40, 32'd8,        4'd12, 32'h01010101, 8};
        vt[6] = '{1'b0, 32'h40, 32'd8,        4'd12, 32'h0,        8};
        vt[7] = '{1'b1, 32'h80, 32'd4,        4'd0,  32'h5,        0};

        reset = 1'b1;
        s_req_i = 0; s_we_i = 0; s_addr_i = '0; s_wdata_i = '0;
        v_req_i = 0; v_we_i = 0; v_base_i = '0; v_stride_i = '0; v_len_i = '0; v_wdata_i = '0;
        pl_we = 0; pl_idx = '0; pl_dat = '0;

        // preload memory and its shadow while reset is held
        for (int i = 0; i < 64; i++) begin
            @(posedge clk_i); #1;
            pl_we = 1'b1; pl_idx = 6'(i);
            pl_dat = (i == 4) ? 32'hDEADBEEF : (32'h5A5A0000 ^ (32'h01000193 * i));
            exp_mem[i] = pl_dat;
        end
        @(posedge clk_i); #1;
        pl_we = 1'b0;
        @(posedge clk_i); #1;
        reset = 1'b0;
        @(negedge clk_i);
        chk("rst_s_rvalid", {255'd0, s_rvalid_o}, '0);
        chk("rst_v_done", {255'd0, v_done_o}, '0);
        chk("rst_s_rdata", {224'd0, s_rdata_o}, '0);
        chk("rst_v_rdata", v_rdata_o, '0);
        chk("rst_mem_en", {254'd0, mem_read_o, mem_write_o}, '0);
        chk("rst_gnts", {254'd0, s_gnt_o, v_gnt_o}, '0);
        @(posedge clk_i); #1;

        s_acc(1'b0, 32'h10, 32'h0);
        s_acc(1'b1, 32'h20, 32'hCAFEF00D);
        s_acc(1'b0, 32'h20, 32'h0);

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // Contention straight after reset: scalar first, vector next, second scalar waits out the burst.
        reset = 1'b1;
        @(posedge clk_i); #1;
        reset = 1'b0;
        push(1'b0, 32'h10, 32'h0);
        exp_rd = '0;
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * k);
            exp_rd[k*32 +: 32] = exp_mem[a[7:2]];
            push(1'b0, a, 32'h0);
        end
        push(1'b1, 32'h24, 32'h600DF00D);
        s_req_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h10; s_wdata_i = '0;
        v_req_i = 1'b1; v_we_i = 1'b0; v_base_i = 32'h0; v_stride_i = 32'd4; v_len_i = 4'd4;
        @(negedge clk_i);
        chk("cont_s_first", {254'd0, s_gnt_o, v_gnt_o}, {254'd0, 2'b10});
        @(posedge clk_i); #1;
        s_we_i = 1'b1; s_addr_i = 32'h24; s_wdata_i = 32'h600DF00D;
        @(negedge clk_i);
        chk("cont_v_second", {254'd0, s_gnt_o, v_gnt_o}, {254'd0, 2'b01});
        chk("cont_s_rdata", {223'd0, s_rvalid_o, s_rdata_o}, {223'd0, 1'b1, 32'hDEADBEEF});
        @(posedge clk_i); #1;
        v_req_i = 1'b0;
        ok = 1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            if (s_gnt_o !== (c == 5) || v_done_o !== (c == 5) || v_gnt_o !== 1'b0) ok = 0;
        end
        chk("cont_stall_then_gnt", ok, 1);
        chk("cont_v_rdata", v_rdata_o, exp_rd);
        @(posedge clk_i); #1;
        s_req_i = 1'b0;
        @(negedge clk_i);
        chk("cont_write_no_rvalid", {255'd0, s_rvalid_o}, '0);
        @(posedge clk_i); #1;

        // Reset lands on element 2 of a len=6 load: only elements 0 and 1 reach memory.
        push(1'b0, 32'h40, 32'h0);
        push(1'b0, 32'h44, 32'h0);
        v_req_i = 1'b1; v_we_i = 1'b0; v_base_i = 32'h40; v_stride_i = 32'd4; v_len_i = 4'd6;
        @(negedge clk_i);
        chk("rstb_gnt", {255'd0, v_gnt_o}, {255'd0, 1'b1});
        @(posedge clk_i); #1;
        v_req_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        reset = 1'b1;
        @(negedge clk_i);
        chk("rstb_no_access", {254'd0, mem_read_o, mem_write_o}, '0);
        @(posedge clk_i); #1;
        reset = 1'b0;
        push(1'b0, 32'h10, 32'h0);
        s_req_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h10;
        @(negedge clk_i);
        chk("rstb_idle_s_gnt", {255'd0, s_gnt_o}, {255'd0, 1'b1});
        chk("rstb_v_rdata", v_rdata_o, '0);
        @(posedge clk_i); #1;
        s_req_i = 1'b0;
        ok = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (v_done_o !== 1'b0) ok = 0;
        end
        chk("rstb_no_done", ok, 1);
        chk("rstb_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed data memory between two requesters: the scalar load/store stage and the vector load/store unit.
- Scalar requests are single-word, single-cycle accesses.
- Vector requests are strided bursts of up to MAX_VL 32-bit elements. The arbiter sequences each burst one element per cycle.
- Sits between the pipeline MEM stage or vector LSU and the data memory.

Parameters:
- MAX_VL, 8, maximum elements per vector burst. Sets the v_wdata_i/v_rdata_o width to 32*MAX_VL.
- LEN_W, 4, width of v_len_i. Must satisfy 2^LEN_W > MAX_VL.

Ports:
- clk_i  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- s_req_i  in  1  scalar access request; held stable until granted
- s_we_i  in  1  scalar write (1) / read (0)
- s_addr_i  in  32  scalar byte address
- s_wdata_i  in  32  scalar write data
- s_gnt_o  out  1  scalar granted this cycle (combinational)
- s_rvalid_o  out  1  registered pulse; s_rdata_o valid
- s_rdata_o  out  32  scalar read data
- v_req_i  in  1  vector burst request; held stable until v_gnt_o
- v_we_i  in  1  burst is store (1) / load (0)
- v_base_i  in  32  byte address of element 0
- v_stride_i  in  32  byte stride between elements, two's complement
- v_len_i  in  LEN_W  element count, 0..MAX_VL
- v_wdata_i  in  32*MAX_VL  store data; element k in bits [32k+31:32k]
- v_gnt_o  out  1  burst accepted this cycle (combinational)
- v_done_o  out  1  registered pulse; burst complete
- v_rdata_o  out  32*MAX_VL  gathered load data
- mem_addr_o  out  32  memory byte address
- mem_wdata_o  out  32  memory write data
- mem_write_o  out  1  memory write enable
- mem_read_o  out  1  memory read enable
- mem_rdata_i  in  32  memory read data, combinational from mem_addr_o

Behaviour:
- Reset (synchronous, active-high):
  - State is IDLE and prio_v is 0.
  - s_rvalid_o, v_done_o, s_rdata_o and v_rdata_o are all 0.
  - The element counter and the latched burst registers are cleared.
- Reset during a burst abandons it:
  - No further memory access occurs.
  - No v_done_o is issued.
  - v_rdata_o clears.
- FSM state IDLE:
  - Memory outputs are all 0 unless a scalar access is granted.
  - Arbitration, when only one requester is active: that requester wins.
  - When both are active: the scalar wins if prio_v=0, the vector wins if prio_v=1.
  - Scalar grant: s_gnt_o=1 and the memory ports are driven combinationally from s_* in the same cycle. prio_v is set to 1 at the clock edge.
  - Scalar read grant: s_rdata_o captures mem_rdata_i at the edge, and s_rvalid_o=1 the next cycle for one cycle. A write grant produces no s_rvalid_o.
  - Vector grant at cycle T: v_gnt_o=1 and no memory access that cycle. At the edge, base, stride, len, we and wdata are latched, v_rdata_o clears, prio_v is set to 0, and the FSM moves to VBURST (or handles len=0 as below).
- FSM state VBURST:
  - Element k (k=0..len-1) is accessed in cycle T+1+k.
  - Element address is base + k*stride, mod 2^32, produced by a running accumulator with no multiplier.
  - Load element: v_rdata_o lane k captures mem_rdata_i. Store element: mem_wdata_o carries latched lane k.
  - s_gnt_o and v_gnt_o are 0 throughout VBURST; the scalar stalls.
  - On the last element, the next state is IDLE and v_done_o=1 in cycle T+len+1.
  - In cycle T+len+1 the arbiter is in IDLE and may grant again. Because prio_v=0, a waiting scalar wins the tie.
- v_len_i=0: accepted with no memory access; v_done_o=1 at T+1 and v_rdata_o is all zero.
- v_len_i>MAX_VL: clamped to MAX_VL.
- Unused lanes (k≥len) of v_rdata_o read 0.
- v_rdata_o holds its value until the next vector grant or reset.
- mem_read_o and mem_write_o are never both 1 and are never asserted outside a grant or burst cycle.
- Address alignment is not checked; addresses pass through unchanged.

Decomposition:
- Shared package contents:
  - FSM state enum {IDLE, VBURST}
  - MAX_VL and LEN_W defaults
  - lane-slice helper constant ELEM_W=32
- Sub-module vburst_addr_gen: base/stride accumulator and element counter, with load, step and last outputs.
- Arbitration and datapath muxing stay in the top-level module.

Test Plan:
- Scalar read alone: preload mem[0x10]=0xDEADBEEF; s_req=1, we=0, addr=0x10 → s_gnt=1 the same cycle, and s_rvalid=1 with s_rdata=0xDEADBEEF the next cycle.
- Vector store then load: base=0x00, stride=4, len=4, wdata lanes 0x11,0x22,0x33,0x44 → 4 write cycles at addresses 0,4,8,12 and v_done at T+5. The reload returns lanes 0..3 = 0x11..0x44 and lanes 4..7 = 0.
- Contention: s_req and v_req asserted together after reset (prio_v=0) → scalar is granted first and vector the next cycle. The scalar stays stalled through the burst and is granted in the v_done cycle.
- Negative stride with wrap: base=0x04, stride=-4 (0xFFFFFFFC), len=3 → addresses 0x04, 0x00, 0xFFFFFFFC.
- len=0 → v_gnt, then v_done at T+1 with mem_read and mem_write at 0 throughout. len=12 with MAX_VL=8 → exactly 8 accesses.
- Reset asserted at element 2 of a len=6 burst → the next cycle has state IDLE, no further memory access, no v_done and v_rdata=0.
